// File: rtl/seq_div16by8.sv
// seq_div16by8: multi-cycle restoring divider, 2N-bit dividend by N-bit
// divisor, one quotient bit per cycle, MSB first.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (dividend[2N-1:0], divisor[N-1:0])
//   out_valid/out_ready result handshake
//   quotient, remainder N-bit results, updated only on entering DONE
//   div_by_zero         divisor was zero
//   overflow            true quotient does not fit in N bits
//
// Optional: define DIV_ROUND_EN to add a ROUND cycle that rounds the
// quotient to nearest and reports a signed (two's complement) remainder.

module seq_div16by8 #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

`ifdef DIV_ROUND_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, ROUND} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t state, state_nx;

    // Partial remainder stays strictly below the divisor, so N bits hold it;
    // only the trial value needs the extra bit.
    logic [N-1:0]     r;
    logic [N-1:0]     lo;
    logic [N-1:0]     qw;
    logic [N-1:0]     dvs;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0] hi;
    logic [N:0]   t;
    logic [N:0]   t_sub;
    logic         ge;
    logic [N-1:0] r_nx;
    logic [N-1:0] q_nx;
    logic         last;
    logic         special;

    assign hi      = dividend[2*N-1:N];
    assign special = (divisor == '0) || (hi >= divisor);

    assign t     = {r, lo[N-1]};
    assign t_sub = t - {1'b0, dvs};
    assign ge    = t >= {1'b0, dvs};
    assign r_nx  = ge ? t_sub[N-1:0] : t[N-1:0];
    assign q_nx  = {qw[N-2:0], ge};
    assign last  = cnt == CNT_W'(N - 1);

`ifdef DIV_ROUND_EN
    logic         up;
    logic         q_max;
    assign up    = {r, 1'b0} >= {1'b0, dvs};
    assign q_max = &qw;
`endif

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid)
                    state_nx = special ? DONE : RUN;
            end
            RUN: begin
                if (last)
`ifdef DIV_ROUND_EN
                    state_nx = ROUND;
`else
                    state_nx = DONE;
`endif
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
`ifdef DIV_ROUND_EN
            ROUND: state_nx = DONE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            lo          <= '0;
            qw          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (hi >= divisor) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            r           <= hi;
                            lo          <= dividend[N-1:0];
                            qw          <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r  <= r_nx;
                    lo <= lo << 1;
                    qw <= q_nx;
                    if (!last)
                        cnt <= cnt + 1'b1;
`ifndef DIV_ROUND_EN
                    if (last) begin
                        quotient  <= q_nx;
                        remainder <= r_nx;
                    end
`endif
                end
`ifdef DIV_ROUND_EN
                ROUND: begin
                    if (up) begin
                        // Saturate rather than wrap the quotient.
                        if (q_max) begin
                            quotient <= qw;
                            overflow <= 1'b1;
                        end else begin
                            quotient <= qw + 1'b1;
                        end
                        remainder <= r - dvs;
                    end else begin
                        quotient  <= qw;
                        remainder <= r;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
